// File: rtl/spell_commit_pkg.sv
// Shared constants and types for the SPELL commit stage: memory write types,
// FSM state encoding and the stack-pointer wrap fault predicate.
package spell_commit_pkg;

    localparam logic [1:0] MEM_TYPE_NONE = 2'd0;
    localparam logic [1:0] MEM_TYPE_CODE = 2'd1;
    localparam logic [1:0] MEM_TYPE_DATA = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_MEM_WAIT = 3'd1,
        ST_DELAY    = 3'd2,
        ST_SLEEP    = 3'd3,
        ST_HALT     = 3'd4
    } state_t;

    // A commit that moves SP across the 0/31 boundary in either direction.
    function automatic logic guard_fault(input logic [4:0] sp_now, input logic [4:0] sp_next);
        return ((sp_now == 5'd31) && (sp_next == 5'd0)) ||
               ((sp_now < 5'd2) && (sp_next >= 5'd30));
    endfunction

endpackage

// File: rtl/spell_stack_file.sv
// 32x8 register file for the SPELL data stack: two asynchronous read ports,
// two write ports, write port 2 wins when both target the same entry.
module spell_stack_file (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       write_en1,
    input  logic [4:0] write_addr1,
    input  logic [7:0] write_data1,
    input  logic       write_en2,
    input  logic [4:0] write_addr2,
    input  logic [7:0] write_data2,
    input  logic [4:0] read_addr1,
    output logic [7:0] read_data1,
    input  logic [4:0] read_addr2,
    output logic [7:0] read_data2
);

    logic [7:0] entries [32];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) begin
                entries[i] <= 8'h00;
            end
        end else begin
            if (write_en1) begin
                entries[write_addr1] <= write_data1;
            end
            // Later assignment takes precedence on a shared address.
            if (write_en2) begin
                entries[write_addr2] <= write_data2;
            end
        end
    end

    assign read_data1 = entries[read_addr1];
    assign read_data2 = entries[read_addr2];

endmodule

// File: rtl/spell_commit.sv
// Commit stage of the SPELL stack CPU: owns PC/SP/stack, drives memory writes
// and stalls for delay/sleep. Optional SP wrap guard: SPELL_STACK_GUARD_EN.
module spell_commit
    import spell_commit_pkg::*;
#(
    parameter logic [7:0] RESET_PC          = 8'h00,
    parameter int         DELAY_UNIT_CYCLES = 1
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] next_pc,
    input  logic [4:0] next_sp,
    input  logic [1:0] stack_write_count,
    input  logic [7:0] set_stack_top,
    input  logic [7:0] set_stack_belowtop,
    input  logic [1:0] memory_write_type,
    input  logic [7:0] memory_write_addr,
    input  logic [7:0] memory_write_data,
    input  logic [7:0] delay_amount,
    input  logic       sleep,
    input  logic       wake,
    output logic [7:0] pc,
    output logic [4:0] sp,
    output logic [7:0] stack_top,
    output logic [7:0] stack_belowtop,
    output logic       mem_req,
    output logic [1:0] mem_type,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_data,
    input  logic       mem_ack,
    output logic       sleeping,
    output logic       stack_fault,
    output state_t     fsm_state
);

    localparam logic [15:0] UNIT = 16'(DELAY_UNIT_CYCLES);

    // Handshake: a bundle transfers on a rising edge where in_valid and in_ready are both high.
    state_t      state, state_n;
    logic [15:0] count_q, count_n;
    logic [7:0]  delay_q;
    logic        sleep_q;
    logic        accept, fault, commit;
    logic        write_top, write_below;
    logic [15:0] delay_new, delay_latched;

    assign in_ready  = (state == ST_IDLE);
    assign accept    = in_valid && in_ready;
    assign commit    = accept && !fault;
    assign fsm_state = state;
    assign mem_req   = (state == ST_MEM_WAIT);
    assign sleeping  = (state == ST_SLEEP);

    assign write_top   = commit && ((stack_write_count == 2'd1) || (stack_write_count == 2'd2));
    assign write_below = commit && (stack_write_count == 2'd2);

    assign delay_new     = {8'h00, delay_amount} * UNIT;
    assign delay_latched = {8'h00, delay_q} * UNIT;

`ifdef SPELL_STACK_GUARD_EN
    assign fault = guard_fault(sp, next_sp);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stack_fault <= 1'b0;
        end else if (accept && fault) begin
            stack_fault <= 1'b1;
        end
    end
`else
    assign fault       = 1'b0;
    assign stack_fault = 1'b0;
`endif

    spell_stack_file u_stack (
        .clock       (clock),
        .reset_n     (reset_n),
        .write_en1   (write_top),
        .write_addr1 (next_sp - 5'd1),
        .write_data1 (set_stack_top),
        .write_en2   (write_below),
        .write_addr2 (next_sp - 5'd2),
        .write_data2 (set_stack_belowtop),
        .read_addr1  (sp - 5'd1),
        .read_data1  (stack_top),
        .read_addr2  (sp - 5'd2),
        .read_data2  (stack_belowtop)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            count_q  <= 16'h0000;
            pc       <= RESET_PC;
            sp       <= 5'd0;
            delay_q  <= 8'h00;
            sleep_q  <= 1'b0;
            mem_type <= MEM_TYPE_NONE;
            mem_addr <= 8'h00;
            mem_data <= 8'h00;
        end else begin
            state   <= state_n;
            count_q <= count_n;
            if (commit) begin
                pc      <= next_pc;
                sp      <= next_sp;
                delay_q <= delay_amount;
                sleep_q <= sleep;
                if (memory_write_type != MEM_TYPE_NONE) begin
                    mem_type <= memory_write_type;
                    mem_addr <= memory_write_addr;
                    mem_data <= memory_write_data;
                end
            end
        end
    end

    always_comb begin
        state_n = state;
        count_n = count_q;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (fault) begin
                        state_n = ST_HALT;
                    end else if (memory_write_type != MEM_TYPE_NONE) begin
                        state_n = ST_MEM_WAIT;
                    end else if (delay_amount != 8'h00) begin
                        state_n = ST_DELAY;
                        count_n = delay_new;
                    end else if (sleep) begin
                        state_n = ST_SLEEP;
                    end
                end
            end
            ST_MEM_WAIT: begin
                // After the write, continue with the rest of the latched bundle.
                if (mem_ack) begin
                    if (delay_q != 8'h00) begin
                        state_n = ST_DELAY;
                        count_n = delay_latched;
                    end else if (sleep_q) begin
                        state_n = ST_SLEEP;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
            end
            ST_DELAY: begin
                if (count_q <= 16'd1) begin
                    state_n = sleep_q ? ST_SLEEP : ST_IDLE;
                    count_n = 16'h0000;
                end else begin
                    count_n = count_q - 16'd1;
                end
            end
            ST_SLEEP: begin
                if (wake) begin
                    state_n = ST_IDLE;
                end
            end
            ST_HALT: begin
                state_n = ST_HALT;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

endmodule
